nr_frame_sequencer: RTL and testbench

Sequences the noise-reduction filter core over one source frame, twice: an averaging pass and then a median pass. Generates the raster read addresses and the filter mode, and realigns the filter output into the 27-bit `DPo` pixel bus consumed by the image capture monitor. Also produces the line-enable gaps and the inter-pass flag that the monitor synchronises on. Sits between the source frame buffer, the filter core and the capture/output stage.

---
 rtl/nr_frame_sequencer_if.sv | 25 ++
 rtl/nr_frame_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_nr_frame_sequencer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nr_frame_sequencer_if.sv
// rtl/nr_frame_sequencer_if.sv - control, frame-buffer, filter and DPo signals of nr_frame_sequencer
interface nr_frame_sequencer_if;
  logic        start;
  logic        abort;
  logic [11:0] Hsize;
  logic [10:0] Vsize;
  logic        src_rd;
  logic [11:0] src_x;
  logic [10:0] src_y;
  logic        flt_mode;
  logic [23:0] flt_data;
  logic [26:0] DPo;
  logic        busy;
  logic        done;

  modport slave (
    input  start, abort, Hsize, Vsize, flt_data,
    output src_rd, src_x, src_y, flt_mode, DPo, busy, done
  );

  modport master (
    output start, abort, Hsize, Vsize, flt_data,
    input  src_rd, src_x, src_y, flt_mode, DPo, busy, done
  );
endinterface

// File: rtl/nr_frame_sequencer.sv
// rtl/nr_frame_sequencer.sv - raster sequencer for average/median filter passes with DPo realignment
// Optional feature macro: NR_MEDIAN_PASS_EN (adds the median pass after VGAP).
module nr_frame_sequencer #(
  parameter int HBLANK   = 16,
  parameter int VBLANK   = 64,
  parameter int PIPE_LAT = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  nr_frame_sequencer_if.slave  seq_if
);

`ifdef NR_MEDIAN_PASS_EN
  localparam bit TwoPass = 1'b1;
`else
  localparam bit TwoPass = 1'b0;
`endif

  localparam int MaxHv  = (HBLANK > VBLANK) ? HBLANK : VBLANK;
  localparam int MaxCnt = (MaxHv > PIPE_LAT + 1) ? MaxHv : PIPE_LAT + 1;
  localparam int CW     = $clog2(MaxCnt) + 1;
  localparam logic [CW-1:0] HgapLast  = CW'(HBLANK - 1);
  localparam logic [CW-1:0] DrainLast = CW'(PIPE_LAT);
  localparam logic [CW-1:0] VgapLast  = CW'(VBLANK - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LINE, S_HGAP, S_DRAIN, S_VGAP, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [11:0]   hsize_q, hsize_d;
  logic [10:0]   vsize_q, vsize_d;
  logic [11:0]   x_q, x_d;
  logic [10:0]   y_q, y_d;
  logic [11:0]   hold_x_q;
  logic [10:0]   hold_y_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mode_q, mode_d;
  logic [PIPE_LAT-1:0] de_sr_q, de_sr_d;
  logic [PIPE_LAT-1:0] fp_sr_q, fp_sr_d;
  logic [26:0]   dpo_q, dpo_d;
  logic          rd;
  logic          tap_de;
  logic          tap_fp;
  logic          abort_hit;

  assign tap_de    = de_sr_q[PIPE_LAT-1];
  assign tap_fp    = fp_sr_q[PIPE_LAT-1];
  assign abort_hit = seq_if.abort && (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    hsize_d = hsize_q;
    vsize_d = vsize_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    rd      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (seq_if.start && !seq_if.abort) begin
          if ((seq_if.Hsize != '0) && (seq_if.Vsize != '0)) begin
            hsize_d = seq_if.Hsize;
            vsize_d = seq_if.Vsize;
            x_d     = '0;
            y_d     = '0;
            mode_d  = 1'b0;
            state_d = S_LINE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_LINE: begin
        rd = 1'b1;
        if (x_q == hsize_q - 12'd1) begin
          x_d   = '0;
          cnt_d = '0;
          if (y_q == vsize_q - 11'd1) begin
            state_d = S_DRAIN;
          end else begin
            y_d     = y_q + 11'd1;
            state_d = S_HGAP;
          end
        end else begin
          x_d = x_q + 12'd1;
        end
      end
      S_HGAP: begin
        if (cnt_q == HgapLast) state_d = S_LINE;
        else                   cnt_d   = cnt_q + CW'(1);
      end
      S_DRAIN: begin
        // Held until the last read has crossed the filter and left DPo.
        if (cnt_q == DrainLast) begin
          cnt_d = '0;
          if (TwoPass && !mode_q) begin
            mode_d  = 1'b1;
            y_d     = '0;
            state_d = S_VGAP;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_VGAP: begin
        if (cnt_q == VgapLast) state_d = S_LINE;
        else                   cnt_d   = cnt_q + CW'(1);
      end
      S_DONE: begin
        mode_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort_hit) begin
      state_d = S_IDLE;
      mode_d  = 1'b0;
    end

    de_sr_d[0] = rd;
    fp_sr_d[0] = rd && (x_q == '0) && (y_q == '0);
    for (int i = 1; i < PIPE_LAT; i++) begin
      de_sr_d[i] = de_sr_q[i-1];
      fp_sr_d[i] = fp_sr_q[i-1];
    end

    dpo_d = {state_d == S_VGAP, tap_de && tap_fp, tap_de,
             tap_de ? seq_if.flt_data : 24'd0};

    if (abort_hit) begin
      de_sr_d = '0;
      fp_sr_d = '0;
      dpo_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      hsize_q  <= '0;
      vsize_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      hold_x_q <= '0;
      hold_y_q <= '0;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      de_sr_q  <= '0;
      fp_sr_q  <= '0;
      dpo_q    <= '0;
    end else begin
      state_q  <= state_d;
      hsize_q  <= hsize_d;
      vsize_q  <= vsize_d;
      x_q      <= x_d;
      y_q      <= y_d;
      hold_x_q <= seq_if.src_x;
      hold_y_q <= seq_if.src_y;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      de_sr_q  <= de_sr_d;
      fp_sr_q  <= fp_sr_d;
      dpo_q    <= dpo_d;
    end
  end

  // Read address is live only during LINE; otherwise the last issued address is held.
  assign seq_if.src_rd   = rd;
  assign seq_if.src_x    = rd ? x_q : hold_x_q;
  assign seq_if.src_y    = rd ? y_q : hold_y_q;
  assign seq_if.flt_mode = mode_q;
  assign seq_if.DPo      = dpo_q;
  assign seq_if.busy     = (state_q != S_IDLE);
  assign seq_if.done     = (state_q == S_DONE);

endmodule

// File: tb/tb_nr_frame_sequencer.sv
// tb/tb_nr_frame_sequencer.sv - self-checking bench for nr_frame_sequencer
module tb_nr_frame_sequencer;
  localparam int HB = 2;
  localparam int VB = 64;
  localparam int PL = 4;
`ifdef NR_MEDIAN_PASS_EN
  localparam int NP         = 2;
  localparam int EXP_DONE_A = 95;
  localparam int EXP_B26_A  = 64;
  localparam int EXP_DONE_C = 101;
  localparam int ABORT_OFS  = 88;
`else
  localparam int NP         = 1;
  localparam int EXP_DONE_A = 16;
  localparam int EXP_B26_A  = 0;
  localparam int EXP_DONE_C = 19;
  localparam int ABORT_OFS  = 9;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;

  nr_frame_sequencer_if bus();

  nr_frame_sequencer #(.HBLANK(HB), .VBLANK(VB), .PIPE_LAT(PL)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .seq_if (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: timeline of one accepted start, derived from sizes and blank lengths.
  bit          m_act = 1'b0;
  int          m_t = 0, m_h = 0, m_v = 0;
  logic [11:0] m_hx = '0;
  logic [10:0] m_hy = '0;

  function automatic int f_plen();
    return m_v * (m_h + HB) - HB + PL + 1;
  endfunction

  function automatic int f_kdone();
    if (m_h == 0 || m_v == 0) return 1;
    return 1 + NP * f_plen() + (NP - 1) * VB;
  endfunction

  function automatic int f_pstart(input int p);
    return 1 + p * (f_plen() + VB);
  endfunction

  function automatic bit f_read(input int k, output int p, output int x, output int y);
    p = 0; x = 0; y = 0;
    if (m_h == 0 || m_v == 0) return 1'b0;
    for (int i = 0; i < NP; i++) begin
      int o;
      o = k - f_pstart(i);
      if (o >= 0 && o < m_v * (m_h + HB) - HB && (o % (m_h + HB)) < m_h) begin
        p = i; x = o % (m_h + HB); y = o / (m_h + HB);
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  int n_de, n_b26, n_done, n_rd, n_busy, first_de, done_cyc;

  task automatic clear_mon();
    n_de = 0; n_b26 = 0; n_done = 0; n_rd = 0; n_busy = 0; first_de = -1; done_cyc = -1;
  endtask

  task automatic model_cycle();
    int k, kd, p, x, y, p2, x2, y2;
    bit rd, de, bsy, dn, md, b26;
    logic [11:0] ex;
    logic [10:0] ey;
    logic [23:0] pix;
    logic [53:0] expv, actv;
    k = cyc - m_t;
    kd = f_kdone();
    bsy = m_act && k >= 1 && k <= kd;
    rd = 0; de = 0; dn = 0; md = 0; b26 = 0; pix = '0; x2 = 0; y2 = 0; p2 = 0;
    if (bsy) begin
      rd = f_read(k, p, x, y);
      de = f_read(k - 1 - PL, p2, x2, y2);
      dn = (k == kd);
      if (NP == 2 && m_h != 0 && m_v != 0) begin
        md  = (k >= f_pstart(1) - VB);
        b26 = md && (k < f_pstart(1));
      end
    end
    ex = rd ? 12'(x) : m_hx;
    ey = rd ? 11'(y) : m_hy;
    m_hx = ex;
    m_hy = ey;
    if (de) pix = {1'(p2), 11'(y2), 12'(x2)};
    expv = {rd, ex, ey, md, b26, de && x2 == 0 && y2 == 0, de, pix, bsy, dn};
    actv = {bus.src_rd, bus.src_x, bus.src_y, bus.flt_mode, bus.DPo, bus.busy, bus.done};
    chk($sformatf("cycle %0d outputs", cyc), 64'(actv), 64'(expv));

    n_de   += int'(bus.DPo[24]);
    n_b26  += int'(bus.DPo[26]);
    n_done += int'(bus.done);
    n_rd   += int'(bus.src_rd);
    n_busy += int'(bus.busy);
    if (bus.DPo[24] && first_de < 0) first_de = cyc;
    if (bus.done) done_cyc = cyc;

    if (bus.abort && bsy) m_act = 1'b0;
    else if (bus.start && !bus.abort && !bsy) begin
      m_act = 1'b1; m_t = cyc; m_h = int'(bus.Hsize); m_v = int'(bus.Vsize);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_act = 1'b0; m_hx = '0; m_hy = '0;
      end else begin
        model_cycle();
      end
    end
  end

  // Filter stub: returns the {pass, y, x} marker of each read PIPE_LAT cycles later, junk otherwise.
  logic [24:0] hist [64];
  initial begin
    int idx;
    for (int i = 0; i < 64; i++) hist[i] = '0;
    bus.flt_data = 24'hA5A5A5;
    forever begin
      @(negedge clk);
      hist[cyc % 64] = {bus.src_rd, bus.flt_mode, bus.src_y, bus.src_x};
      idx = (cyc + 64 - PL) % 64;
      bus.flt_data = hist[idx][24] ? hist[idx][23:0] : 24'hA5A5A5;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int h, input int v, output int t0);
    bus.Hsize = 12'(h);
    bus.Vsize = 11'(v);
    bus.start = 1'b1;
    t0 = cyc;
    step(1);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 400) begin
      step(1);
      n++;
    end
    if (n >= 400) begin
      checks++; errors++;
      $display("FAIL %s: busy still %b after %0d cycles, required 0", nm, bus.busy, n);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({bus.src_rd, bus.src_x, bus.src_y, bus.flt_mode, bus.DPo, bus.busy, bus.done});
  endfunction

  initial begin
    int t0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.Hsize = '0; bus.Vsize = '0;
    clear_mon();
    #1 rst_n = 1'b0;
    step(3);
    chk("reset outputs", all_outs(), 64'd0);
    rst_n = 1'b1;
    step(2);

    // Main sequence with an ignored start while busy.
    clear_mon();
    pulse_start(4, 2, t0);
    step(7);
    bus.Hsize = 12'd9; bus.Vsize = 11'd9; bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    wait_idle("A idle");
    step(2);
    chk("A done cycle", 64'(done_cyc - t0), 64'(EXP_DONE_A));
    chk("A done count", 64'(n_done), 64'd1);
    chk("A DE count", 64'(n_de), 64'(8 * NP));
    chk("A pass flag cycles", 64'(n_b26), 64'(EXP_B26_A));
    chk("A first DE latency", 64'(first_de - t0), 64'd6);
    chk("A busy cycles", 64'(n_busy), 64'(EXP_DONE_A));

    // start and abort together in IDLE.
    clear_mon();
    bus.Hsize = 12'd4; bus.Vsize = 11'd2; bus.start = 1'b1; bus.abort = 1'b1;
    step(1);
    bus.start = 1'b0; bus.abort = 1'b0;
    step(5);
    chk("start+abort busy cycles", 64'(n_busy), 64'd0);
    chk("start+abort reads", 64'(n_rd), 64'd0);

    // Zero sizes.
    clear_mon();
    pulse_start(0, 5, t0);
    wait_idle("Z idle");
    step(2);
    chk("Z done cycle", 64'(done_cyc - t0), 64'd1);
    chk("Z busy cycles", 64'(n_busy), 64'd1);
    chk("Z reads", 64'(n_rd), 64'd0);
    clear_mon();
    pulse_start(7, 0, t0);
    wait_idle("Z2 idle");
    step(2);
    chk("Z2 reads", 64'(n_rd), 64'd0);

    // Abort at (y=1, x=2) of the last pass.
    clear_mon();
    pulse_start(4, 2, t0);
    step(ABORT_OFS - 1);
    chk("abort point read", 64'({bus.src_rd, bus.src_x, bus.src_y}), 64'({1'b1, 12'd2, 11'd1}));
    bus.abort = 1'b1;
    step(1);
    bus.abort = 1'b0;
    chk("abort DPo", 64'(bus.DPo), 64'd0);
    chk("abort busy", 64'(bus.busy), 64'd0);
    chk("abort flt_mode", 64'(bus.flt_mode), 64'd0);
    step(3);
    chk("abort done count", 64'(n_done), 64'd0);

    // Rerun after abort with a new size.
    clear_mon();
    pulse_start(3, 3, t0);
    chk("rerun first read", 64'({bus.src_rd, bus.src_x, bus.src_y, bus.flt_mode}), 64'({1'b1, 12'd0, 11'd0, 1'b0}));
    wait_idle("C idle");
    step(2);
    chk("C done cycle", 64'(done_cyc - t0), 64'(EXP_DONE_C));
    chk("C DE count", 64'(n_de), 64'(9 * NP));

    // Asynchronous reset in DRAIN.
    clear_mon();
    pulse_start(2, 1, t0);
    step(3);
    #2 rst_n = 1'b0;
    #1 chk("async reset outputs", all_outs(), 64'd0);
    step(2);
    rst_n = 1'b1;
    clear_mon();
    step(10);
    chk("post reset busy cycles", 64'(n_busy), 64'd0);
    chk("post reset reads", 64'(n_rd), 64'd0);
    clear_mon();
    pulse_start(1, 1, t0);
    wait_idle("R idle");
    step(2);
    chk("R done count", 64'(n_done), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end
endmodule
